mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a byte TX FIFO, status register
// and a sticky tohost halt latch for a simple core's store port.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        halt,
  output logic [31:0] halt_code
);
  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          ovf, full, busy, push, pop, ovf_set, ovf_clr;
  logic          hit_tx, hit_st, hit_th;
  logic [31:0]   off;
  // Word offset into the window; byte-lane bits are masked so they never matter.
  assign off     = (addr & 32'hFFFF_FFFC) - (BASE_ADDR & 32'hFFFF_FFFC);
  assign sel     = (off == 32'd0) || (off == 32'd4) || (off == 32'd8);
  assign hit_tx  = we && off == 32'd0;
  assign hit_st  = we && off == 32'd4;
  assign hit_th  = we && off == 32'd8;
  assign full    = count == DEPTH;
  assign busy    = count != '0 || state != IDLE;
  assign push    = hit_tx && !full;
  assign pop     = state == IDLE && count != '0;
  assign ovf_set = hit_tx && full;
  assign ovf_clr = hit_st && wdata[2];
  assign rdata   = off == 32'd4 ? {29'b0, ovf, busy, full} : 32'b0;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata[7:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      halt      <= 1'b0;
      halt_code <= 32'b0;
      state     <= IDLE;
      cnt       <= 16'b0;
      bit_idx   <= 3'b0;
      shift     <= 8'b0;
      tx        <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      ovf   <= ovf_set || (ovf && !ovf_clr);
      if (hit_th && !halt) begin
        halt      <= 1'b1;
        halt_code <= wdata;
      end
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    unique case (state)
      IDLE:
        if (pop) begin
          state_n = START;
          cnt_n   = RELOAD;
          shift_n = mem[rptr];
        end
      START:
        if (cnt == 16'd0) begin
          state_n = DATA;
          cnt_n   = RELOAD;
          bit_n   = 3'd0;
        end else cnt_n = cnt - 16'd1;
      DATA:
        if (cnt == 16'd0) begin
          cnt_n   = RELOAD;
          shift_n = shift >> 1;
          bit_n   = bit_idx + 3'd1;
          state_n = bit_idx == 3'd7 ? STOP : DATA;
        end else cnt_n = cnt - 16'd1;
      STOP:
        if (cnt == 16'd0) state_n = IDLE;
        else cnt_n = cnt - 16'd1;
      default: state_n = IDLE;
    endcase
  end
endmodule
